// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield defaults, FSM state type and piece mask table
// Contents:
//   ROWS_DEF / COLS_DEF : default playfield size
//   state_t             : controller states
//   PIECE_O             : piece code loaded at reset
//   PIECE_MASK          : 4x4 occupancy per piece code, bit index = r*4 + c
package tetris_pkg;

   localparam int ROWS_DEF = 20;
   localparam int COLS_DEF = 10;

   typedef enum logic [2:0] {
      ST_SPAWN     = 3'd0,
      ST_FALL      = 3'd1,
      ST_LOCK      = 3'd2,
      ST_CLEAR     = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam logic [2:0] PIECE_O = 3'd1;

   // Codes: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L, 7 aliases O.
   localparam logic [15:0] PIECE_MASK [0:7] = '{
      16'h000F,   // I : row 0 cols 0-3
      16'h0066,   // O : rows 0-1 cols 1-2
      16'h0027,   // T : row 0 cols 0-2, row 1 col 1
      16'h0036,   // S : row 0 cols 1-2, row 1 cols 0-1
      16'h0063,   // Z : row 0 cols 0-1, row 1 cols 1-2
      16'h0071,   // J : row 0 col 0, row 1 cols 0-2
      16'h0074,   // L : row 0 col 2, row 1 cols 0-2
      16'h0066    // 7 : same as O
   };

endpackage

// File: rtl/piece_fits.sv
// rtl/piece_fits.sv - combinational placement test of a piece against the locked grid
// Ports:
//   i_grid  : locked cells, bit index = row*COLS + col
//   i_piece : candidate piece code
//   i_row   : candidate top row of the 4x4 mask
//   i_col   : candidate left column of the 4x4 mask (signed, may be -1)
//   o_fits  : every set mask cell lies inside the field and on a free cell
module piece_fits
   import tetris_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input  logic [ROWS*COLS-1:0] i_grid,
   input  logic [2:0]           i_piece,
   input  logic [5:0]           i_row,
   input  logic signed [5:0]    i_col,
   output logic                 o_fits
);

   localparam int IDXW = $clog2(ROWS*COLS);

   logic [15:0] w_mask;

   assign w_mask = PIECE_MASK[i_piece];

   always_comb begin
      int rr;
      int cc;
      o_fits = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            rr = int'(i_row) + r;
            cc = int'(i_col) + c;
            if (w_mask[4'(r*4 + c)]) begin
               if (rr >= ROWS || cc < 0 || cc >= COLS) begin
                  o_fits = 1'b0;
               end else if (i_grid[IDXW'(rr*COLS + cc)]) begin
                  o_fits = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/piece_drop_ctrl.sv
// rtl/piece_drop_ctrl.sv - falling-block game core: spawn, move, lock, line clear
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   drop_tick                      : gravity pulse (same effect as btn_down)
//   btn_left, btn_right, btn_down  : one-cycle move requests
//   piece_sel                      : piece code latched at spawn
//   q_row, q_col                   : renderer cell query
//   q_occupied, q_active           : query result (locked or falling / falling only)
//   lines_cleared                  : saturating cleared-row count
//   game_over                      : high once a spawn collides
module piece_drop_ctrl
   import tetris_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       drop_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_down,
   input  logic [2:0] piece_sel,
   input  logic [4:0] q_row,
   input  logic [3:0] q_col,
   output logic       q_occupied,
   output logic       q_active,
   output logic [7:0] lines_cleared,
   output logic       game_over
);

   localparam int CELLS = ROWS*COLS;
   localparam int IDXW  = $clog2(CELLS);

   state_t           r_state, w_state_nxt;
   logic [CELLS-1:0] r_grid, w_grid_nxt;
   logic [2:0]       r_piece, w_piece_nxt;
   logic [4:0]       r_row, w_row_nxt;
   logic [3:0]       r_col, w_col_nxt;
   logic [7:0]       r_lines, w_lines_nxt;
   logic [4:0]       r_scan, w_scan_nxt;

   logic [15:0]      w_mask;
   logic [CELLS-1:0] w_active;
   logic             w_row_full;
   logic             w_fit_down, w_fit_left, w_fit_right, w_fit_spawn;
   logic             w_in_range;
   logic [IDXW-1:0]  w_qidx;

   piece_fits #(.ROWS(ROWS), .COLS(COLS)) u_fit_down (
      .i_grid(r_grid), .i_piece(r_piece), .i_row({1'b0, r_row} + 6'd1),
      .i_col($signed({2'b00, r_col})), .o_fits(w_fit_down));

   piece_fits #(.ROWS(ROWS), .COLS(COLS)) u_fit_left (
      .i_grid(r_grid), .i_piece(r_piece), .i_row({1'b0, r_row}),
      .i_col($signed({2'b00, r_col}) - 6'sd1), .o_fits(w_fit_left));

   piece_fits #(.ROWS(ROWS), .COLS(COLS)) u_fit_right (
      .i_grid(r_grid), .i_piece(r_piece), .i_row({1'b0, r_row}),
      .i_col($signed({2'b00, r_col}) + 6'sd1), .o_fits(w_fit_right));

   piece_fits #(.ROWS(ROWS), .COLS(COLS)) u_fit_spawn (
      .i_grid(r_grid), .i_piece(piece_sel), .i_row(6'd0),
      .i_col(6'sd3), .o_fits(w_fit_spawn));

   assign w_mask = PIECE_MASK[r_piece];

   // Footprint of the current piece on the field; used both for LOCK and queries.
   always_comb begin
      int rr;
      int cc;
      w_active = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            rr = int'(r_row) + r;
            cc = int'(r_col) + c;
            if (w_mask[4'(r*4 + c)] && rr < ROWS && cc < COLS) begin
               w_active[IDXW'(rr*COLS + cc)] = 1'b1;
            end
         end
      end
   end

   assign w_row_full = &r_grid[IDXW'(int'(r_scan)*COLS) +: COLS];

   always_comb begin
      w_state_nxt = r_state;
      w_grid_nxt  = r_grid;
      w_piece_nxt = r_piece;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_lines_nxt = r_lines;
      w_scan_nxt  = r_scan;
      case (r_state)
         ST_SPAWN: begin
            w_piece_nxt = piece_sel;
            w_row_nxt   = 5'd0;
            w_col_nxt   = 4'd3;
            w_state_nxt = w_fit_spawn ? ST_FALL : ST_GAME_OVER;
         end
         ST_FALL: begin
            if (drop_tick || btn_down) begin
               if (w_fit_down) w_row_nxt = r_row + 5'd1;
               else            w_state_nxt = ST_LOCK;
            end else if (btn_left) begin
               // The column register is unsigned, so col 0 is the leftmost
               // position even when mask column 0 is empty (O piece).
               if (r_col != 4'd0 && w_fit_left) w_col_nxt = r_col - 4'd1;
            end else if (btn_right) begin
               if (w_fit_right) w_col_nxt = r_col + 4'd1;
            end
         end
         ST_LOCK: begin
            w_grid_nxt  = r_grid | w_active;
            w_scan_nxt  = 5'(ROWS - 1);
            w_state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (w_row_full) begin
               // Rows at or above the scan index move down one; the same
               // index is rescanned because a full row may have moved into it.
               for (int r = 1; r < ROWS; r++) begin
                  if (5'(r) <= r_scan) w_grid_nxt[r*COLS +: COLS] = r_grid[(r-1)*COLS +: COLS];
               end
               w_grid_nxt[0 +: COLS] = '0;
               if (r_lines != 8'hFF) w_lines_nxt = r_lines + 8'd1;
            end else if (r_scan == 5'd0) begin
               w_state_nxt = ST_SPAWN;
            end else begin
               w_scan_nxt = r_scan - 5'd1;
            end
         end
         ST_GAME_OVER: begin
         end
         default: w_state_nxt = ST_SPAWN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SPAWN;
         r_grid  <= '0;
         r_piece <= PIECE_O;
         r_row   <= 5'd0;
         r_col   <= 4'd3;
         r_lines <= 8'd0;
         r_scan  <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_grid  <= w_grid_nxt;
         r_piece <= w_piece_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_lines <= w_lines_nxt;
         r_scan  <= w_scan_nxt;
      end
   end

   assign w_in_range    = (int'(q_row) < ROWS) && (int'(q_col) < COLS);
   assign w_qidx        = IDXW'(int'(q_row)*COLS + int'(q_col));
   assign q_active      = w_in_range && (r_state == ST_FALL) && w_active[w_qidx];
   assign q_occupied    = w_in_range && (r_grid[w_qidx] || q_active);
   assign lines_cleared = r_lines;
   assign game_over     = (r_state == ST_GAME_OVER);

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb/tb_piece_drop_ctrl.sv - randomized and directed checks of piece_drop_ctrl against a cell-level model
module tb_piece_drop_ctrl;

   localparam int ROWS = 20;
   localparam int COLS = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       drop_tick, btn_left, btn_right, btn_down;
   logic [2:0] piece_sel;
   logic [4:0] q_row;
   logic [3:0] q_col;
   logic       q_occupied, q_active, game_over;
   logic [7:0] lines_cleared;

   int n_checks = 0;
   int n_pass   = 0;

   always #500 clk = ~clk;

   piece_drop_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk(clk), .rst(rst), .drop_tick(drop_tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
      .piece_sel(piece_sel), .q_row(q_row), .q_col(q_col),
      .q_occupied(q_occupied), .q_active(q_active),
      .lines_cleared(lines_cleared), .game_over(game_over));

   // Model: piece shapes as cell lists, locked field as a 2-D bit array;
   // LOCK+CLEAR is collapsed into one busy interval of known length.
   typedef enum {M_SPAWN, M_FALL, M_BUSY, M_OVER} mstate_t;
   mstate_t m_st;
   bit      m_grid [ROWS][COLS];
   int      m_piece, m_row, m_col, m_lines, m_busy;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int cell_r(input int p, input int k);
      case (p)
         0:       return 0;
         2:       return (k < 3) ? 0 : 1;
         3, 4:    return (k < 2) ? 0 : 1;
         5, 6:    return (k == 0) ? 0 : 1;
         default: return k / 2;
      endcase
   endfunction

   function automatic int cell_c(input int p, input int k);
      case (p)
         0:       return k;
         2:       return (k < 3) ? k : 1;
         3:       return (k < 2) ? k + 1 : k - 2;
         4:       return (k < 2) ? k : k - 1;
         5:       return (k == 0) ? 0 : k - 1;
         6:       return (k == 0) ? 2 : k - 1;
         default: return 1 + k % 2;
      endcase
   endfunction

   function automatic bit m_fits(input int p, input int row, input int col);
      for (int k = 0; k < 4; k++) begin
         int rr = row + cell_r(p, k);
         int cc = col + cell_c(p, k);
         if (rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
         if (m_grid[rr][cc]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit m_active_at(input int r, input int c);
      if (m_st != M_FALL) return 1'b0;
      for (int k = 0; k < 4; k++)
         if (m_row + cell_r(m_piece, k) == r && m_col + cell_c(m_piece, k) == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_occ_at(input int r, input int c);
      if (r >= ROWS || c >= COLS) return 1'b0;
      return m_grid[r][c] | m_active_at(r, c);
   endfunction

   task automatic m_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_grid[r][c] = 1'b0;
      m_lines = 0; m_st = M_SPAWN; m_piece = 1; m_row = 0; m_col = 3; m_busy = 0;
   endtask

   task automatic m_lock_and_clear();
      bit ng [ROWS][COLS];
      int dst = ROWS - 1;
      int nfull = 0;
      for (int k = 0; k < 4; k++) m_grid[m_row + cell_r(m_piece, k)][m_col + cell_c(m_piece, k)] = 1'b1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) ng[r][c] = 1'b0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         int cnt = 0;
         for (int c = 0; c < COLS; c++) cnt += int'(m_grid[r][c]);
         if (cnt == COLS) nfull++;
         else begin
            for (int c = 0; c < COLS; c++) ng[dst][c] = m_grid[r][c];
            dst--;
         end
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_grid[r][c] = ng[r][c];
      m_lines = (m_lines + nfull > 255) ? 255 : m_lines + nfull;
      m_busy  = 1 + ROWS + nfull;
      m_st    = M_BUSY;
   endtask

   task automatic m_step(input bit d, input bit l, input bit rt, input bit dn, input int sel);
      case (m_st)
         M_SPAWN: begin
            m_piece = sel; m_row = 0; m_col = 3;
            m_st = m_fits(sel, 0, 3) ? M_FALL : M_OVER;
         end
         M_FALL: begin
            if (d || dn) begin
               if (m_fits(m_piece, m_row + 1, m_col)) m_row++;
               else m_lock_and_clear();
            end else if (l) begin
               if (m_col > 0 && m_fits(m_piece, m_row, m_col - 1)) m_col--;
            end else if (rt) begin
               if (m_fits(m_piece, m_row, m_col + 1)) m_col++;
            end
         end
         M_BUSY: begin
            m_busy--;
            if (m_busy == 0) m_st = M_SPAWN;
         end
         default: ;
      endcase
   endtask

   task automatic query(input int r, input int c, output logic o, output logic a);
      q_row = 5'(r); q_col = 4'(c);
      #1;
      o = q_occupied; a = q_active;
   endtask

   task automatic check_grid(input string tag);
      int bad = 0;
      logic o, a;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            query(r, c, o, a);
            if (o !== m_occ_at(r, c) || a !== m_active_at(r, c)) bad++;
         end
      check(tag, bad, 0);
   endtask

   task automatic locked_count(output int n);
      logic o, a;
      n = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            query(r, c, o, a);
            if (o && !a) n++;
         end
   endtask

   task automatic expect_cell(input string tag, input int r, input int c, input int eo, input int ea);
      logic o, a;
      query(r, c, o, a);
      check(tag, int'({o, a}), eo * 2 + ea);
   endtask

   task automatic compare_cycle();
      logic o, a;
      int r, c;
      check("game_over", int'(game_over), int'(m_st == M_OVER));
      if (m_st != M_BUSY) check("lines", int'(lines_cleared), m_lines);
      r = $urandom_range(0, 23);
      c = $urandom_range(0, 12);
      query(r, c, o, a);
      check("q_active", int'(a), int'(m_active_at(r, c)));
      if (m_st != M_BUSY) check("q_occupied", int'(o), int'(m_occ_at(r, c)));
   endtask

   task automatic cycle(input bit d, input bit l, input bit rt, input bit dn, input logic [2:0] s);
      drop_tick = d; btn_left = l; btn_right = rt; btn_down = dn; piece_sel = s;
      @(posedge clk);
      m_step(d, l, rt, dn, int'(s));
      @(negedge clk);
      compare_cycle();
   endtask

   // Asserted at a falling edge; the async clear is checked before any clock edge.
   task automatic do_reset();
      drop_tick = 0; btn_left = 0; btn_right = 0; btn_down = 0;
      rst = 1'b1;
      m_reset();
      #1;
      check("rst_lines", int'(lines_cleared), 0);
      check("rst_game_over", int'(game_over), 0);
      check_grid("rst_grid");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drop_piece(input logic [2:0] nxt);
      while (m_st == M_FALL) cycle(1, 0, 0, 0, nxt);
      while (m_st == M_BUSY) cycle(0, 0, 0, 0, nxt);
      if (m_st == M_SPAWN) cycle(0, 0, 0, 0, nxt);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   lat, n;
      logic o, a;
      rst = 1'b0; drop_tick = 0; btn_left = 0; btn_right = 0; btn_down = 0;
      piece_sel = 3'd0; q_row = 5'd0; q_col = 4'd0;
      @(negedge clk);

      // O dropped by 19 ticks locks at rows 18-19, then a new O appears.
      do_reset();
      cycle(0, 0, 0, 0, 3'd1);
      expect_cell("spawn_o", 0, 4, 1, 1);
      for (int i = 0; i < 19; i++) cycle(1, 0, 0, 0, 3'd1);
      lat = 0; a = 1'b0;
      while (!a && lat < 40) begin
         cycle(0, 0, 0, 0, 3'd1);
         lat++;
         query(0, 4, o, a);
      end
      check("lock_respawn_latency", lat, 22);
      expect_cell("locked_18_4", 18, 4, 1, 0);
      expect_cell("locked_18_5", 18, 5, 1, 0);
      expect_cell("locked_19_4", 19, 4, 1, 0);
      expect_cell("locked_19_5", 19, 5, 1, 0);
      expect_cell("locked_19_3", 19, 3, 0, 0);

      // Wall limits.
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 3'd1);
      expect_cell("left_wall_c1", 0, 1, 1, 1);
      expect_cell("left_wall_c0", 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 3'd1);
      expect_cell("right_wall_c9", 0, 9, 1, 1);
      expect_cell("right_wall_c7", 0, 7, 0, 0);

      // Tick wins over left in the same cycle.
      cycle(1, 1, 0, 0, 3'd1);
      expect_cell("prio_1_8", 1, 8, 1, 1);
      expect_cell("prio_0_8", 0, 8, 0, 0);
      expect_cell("prio_1_7", 1, 7, 0, 0);
      expect_cell("out_of_range", 24, 2, 0, 0);

      // Two nearly full bottom rows completed by an O.
      do_reset();
      cycle(0, 0, 0, 0, 3'd0);
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 3'd0);
         drop_piece(3'd0);
         for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 3'd0);
         drop_piece(j == 1 ? 3'd1 : 3'd0);
      end
      drop_piece(3'd1);
      check("clear_lines", int'(lines_cleared), 2);
      locked_count(n);
      check("clear_grid_empty", n, 0);

      // Reset in the middle of a clear scan.
      while (m_st == M_FALL) cycle(1, 0, 0, 0, 3'd1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 3'd1);
      do_reset();
      cycle(0, 0, 0, 0, 3'd2);
      expect_cell("spawn_t_after_rst", 0, 3, 1, 1);
      expect_cell("spawn_t_row1", 1, 4, 1, 1);

      // Column of O pieces until spawn collides.
      do_reset();
      cycle(0, 0, 0, 0, 3'd1);
      for (int i = 0; i < 15 && m_st != M_OVER; i++) drop_piece(3'd1);
      check("stack_game_over", int'(game_over), 1);
      locked_count(n);
      check("stack_cells", n, 40);
      for (int i = 0; i < 30; i++)
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      locked_count(n);
      check("over_frozen_cells", n, 40);
      check("over_frozen_lines", int'(lines_cleared), 0);
      check("over_frozen_flag", int'(game_over), 1);

      // Random play with occasional resets.
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         if (m_st == M_OVER || $urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  3'($urandom_range(0, 7)));
         end
         if (i % 25 == 0 && m_st != M_BUSY) check_grid("rand_grid");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
